// File: rtl/seq_div_hilo.sv
// Sequential non-restoring 32-bit signed/unsigned divider. Each clock produces
// one quotient bit. The quotient is written to LO and the remainder to HI.
module seq_div_hilo #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_in_q, b_in_q;
   logic             sop_q, qneg_q, rneg_q;
   logic [WIDTH:0]   p_q, d_q;
   logic [WIDTH-1:0] a_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q, done_q, dbz_q;
   logic [WIDTH-1:0] hi_q, lo_q;

   logic [WIDTH-1:0] a_mag_d, b_mag_d, p_fix_d;
   logic [WIDTH:0]   p_sh_d, p_step_d;

   // Operand magnitudes; negating 0x80000000 yields 2^31 when read unsigned
   always_comb begin
      a_mag_d  = (sop_q && a_in_q[WIDTH-1]) ? WIDTH'(0) - a_in_q : a_in_q;
      b_mag_d  = (sop_q && b_in_q[WIDTH-1]) ? WIDTH'(0) - b_in_q : b_in_q;
      p_sh_d   = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
      p_step_d = p_q[WIDTH] ? p_sh_d + d_q : p_sh_d - d_q;
      p_fix_d  = p_q[WIDTH] ? p_q[WIDTH-1:0] + d_q[WIDTH-1:0] : p_q[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         a_in_q  <= '0;
         b_in_q  <= '0;
         sop_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         p_q     <= '0;
         d_q     <= '0;
         a_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_in_q  <= dividend;
                  b_in_q  <= divisor;
                  sop_q   <= signed_op;
                  dbz_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= PREP;
               end
            end
            PREP: begin
               qneg_q <= sop_q & (a_in_q[WIDTH-1] ^ b_in_q[WIDTH-1]);
               rneg_q <= sop_q & a_in_q[WIDTH-1];
               p_q    <= '0;
               a_q    <= a_mag_d;
               d_q    <= {1'b0, b_mag_d};
               cnt_q  <= CW'(WIDTH - 1);
               if (b_in_q == '0) begin
                  lo_q    <= '1;
                  hi_q    <= a_in_q;
                  dbz_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  dbz_q   <= 1'b0;
                  state_q <= ITER;
               end
            end
            ITER: begin
               p_q   <= p_step_d;
               a_q   <= {a_q[WIDTH-2:0], ~p_step_d[WIDTH]};
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) state_q <= FIX;
            end
            FIX: begin
               lo_q    <= qneg_q ? WIDTH'(0) - a_q : a_q;
               hi_q    <= rneg_q ? WIDTH'(0) - p_fix_d : p_fix_d;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_seq_div_hilo.sv
// Directed self-checking bench for seq_div_hilo: latency, busy window, signed and
// unsigned results, divide-by-zero, ignored restart and asynchronous abort.
module tb_seq_div_hilo;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic        signed_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   seq_div_hilo #(.WIDTH(32)) dut (
      .clk         (clk),
      .clr         (clr),
      .start       (start),
      .signed_op   (signed_op),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one divide and follow it to done; latency counts the accepting edge as edge 1
   task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_dbz, input int exp_lat, input int exp_busy,
                          input logic inject);
      int n;
      int busy_cnt;
      int extra_done;
      @(posedge clk); #1;
      start = 1'b1; dividend = a; divisor = b; signed_op = s;
      @(posedge clk); #1;
      start = 1'b0; dividend = ~a; divisor = b ^ 32'h0000_0101; signed_op = ~s;
      n = 0;
      busy_cnt = 0;
      while (n < 100 && !done) begin
         if (busy) busy_cnt++;
         if (inject && n == 10) begin
            start = 1'b1; dividend = 32'h0000_0055; divisor = 32'h0000_0003; signed_op = 1'b0;
         end
         if (inject && n == 11) start = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      check({name, "_timeout"}, 32'(done), 32'd1);
      check({name, "_latency"}, 32'(n + 1), 32'(exp_lat));
      check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
      check({name, "_busy_at_done"}, 32'(busy), 32'd0);
      check({name, "_lo"}, lo, exp_lo);
      check({name, "_hi"}, hi, exp_hi);
      check({name, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
      @(posedge clk); #1;
      check({name, "_done_pulse"}, 32'(done), 32'd0);
      check({name, "_dbz_hold"}, 32'(div_by_zero), 32'(exp_dbz));
      if (inject) begin
         extra_done = 0;
         for (int i = 0; i < 40; i++) begin
            if (done) extra_done++;
            @(posedge clk); #1;
         end
         check({name, "_no_second_done"}, 32'(extra_done), 32'd0);
         check({name, "_lo_kept"}, lo, exp_lo);
         check({name, "_hi_kept"}, hi, exp_hi);
      end
   endtask

   initial begin
      clr = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      clr = 1'b1;

      run_div("u100_7",  32'd100,       32'd7,         1'b0, 32'h0000_000E, 32'h0000_0002, 1'b0, 35, 34, 1'b0);
      run_div("s-100_7", 32'hFFFF_FF9C, 32'h0000_0007, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 35, 34, 1'b0);
      run_div("u_ff9c_7",32'hFFFF_FF9C, 32'h0000_0007, 1'b0, 32'h2492_4916, 32'h0000_0002, 1'b0, 35, 34, 1'b0);
      run_div("s_min_m1",32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0, 35, 34, 1'b0);
      run_div("u_max_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 35, 34, 1'b0);
      run_div("s100_m7", 32'd100,       32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'h0000_0002, 1'b0, 35, 34, 1'b0);
      run_div("div0",    32'h1234_5678, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1,  2,  1, 1'b0);
      run_div("after0",  32'd100,       32'd7,         1'b0, 32'h0000_000E, 32'h0000_0002, 1'b0, 35, 34, 1'b0);
      run_div("ignore",  32'd1000,      32'd33,        1'b0, 32'h0000_001E, 32'h0000_000A, 1'b0, 35, 34, 1'b1);

      // Abort 50/5 mid-iteration with an asynchronous reset
      @(posedge clk); #1;
      start = 1'b1; dividend = 32'd50; divisor = 32'd5; signed_op = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #2;
      clr = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      @(negedge clk);
      clr = 1'b1;
      run_div("post_abort", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 35, 34, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
